hpm_window_detector: RTL and testbench

- Consumer end of the HPM tracer handshake.
- Accepts the 32x64-bit counter snapshot presented with EnableDetect and scans each counter against programmable per-counter lower/upper bounds.
- Reports an anomaly vector and running statistics, then returns EndDetect to release the tracer for the next window.
- Sits between the tracer output and the security/monitor logic.

---
 rtl/hpm_window_detector.sv | 135 +++++++++++++
 tb/tb_hpm_window_detector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hpm_window_detector.sv
// Consumer side of the HPM tracer handshake: snapshots 32 counters, range-checks
// one counter per cycle against programmable bounds, then acknowledges with EndDetect.
module hpm_window_detector #(
  parameter int NUM_HPM = 32,
  parameter int THR_W   = 32,
  parameter int STAT_W  = 16
) (
  input  logic                         clk_h,
  input  logic                         rst_h,
  input  logic [NUM_HPM-1:0][63:0]     HPMin,
  input  logic                         EnableDetect,
  output logic                         EndDetect,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_sel,
  input  logic [4:0]                   cfg_idx,
  input  logic [THR_W-1:0]             cfg_wdata,
  output logic                         cfg_err,
  output logic                         busy,
  output logic                         anomaly,
  output logic [NUM_HPM-1:0]           anomaly_vec,
  output logic [STAT_W-1:0]            window_cnt,
  output logic [STAT_W-1:0]            anomaly_cnt
);

  localparam int IDX_W = $clog2(NUM_HPM);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_LOW} state_t;

  state_t                    state, state_nx;
  logic [NUM_HPM-1:0][63:0]  snap_p0;
  logic [THR_W-1:0]          lo [NUM_HPM];
  logic [THR_W-1:0]          hi [NUM_HPM];
  logic [NUM_HPM-1:0]        mask;
  logic [IDX_W-1:0]          idx;
  logic [NUM_HPM-1:0]        work_vec;

  logic [THR_W-1:0]          cur_val;
  logic                      viol;
  logic                      last;
  logic [NUM_HPM-1:0]        vec_nx;
  logic                      cfg_ok;

  // Counts above the compare width clamp to all-ones rather than wrapping.
  function automatic logic [THR_W-1:0] sat_val(input logic [63:0] v);
    if (|v[63:THR_W]) return '1;
    return v[THR_W-1:0];
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    if (&c) return c;
    return c + STAT_W'(1);
  endfunction

  always_comb begin
    cur_val = sat_val(snap_p0[idx]);
    viol    = mask[idx] && ((cur_val < lo[idx]) || (cur_val > hi[idx]));
    vec_nx  = work_vec | (NUM_HPM'(viol) << idx);
    last    = (idx == IDX_W'(NUM_HPM - 1));
    cfg_ok  = cfg_we && (state == IDLE) && (cfg_sel != 2'd3);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (EnableDetect) state_nx = SCAN;
      SCAN:     if (last) state_nx = WAIT_LOW;
      WAIT_LOW: if (!EnableDetect) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_h) begin
    if (!rst_h) state <= IDLE;
    else        state <= state_nx;
  end

  assign busy = (state != IDLE);

  // Snapshot capture: pure data, only loaded at the request edge.
  always_ff @(posedge clk_h) begin
    if (state == IDLE && EnableDetect) snap_p0 <= HPMin;
  end

  always_ff @(posedge clk_h) begin
    if (!rst_h) begin
      EndDetect   <= 1'b0;
      cfg_err     <= 1'b0;
      anomaly     <= 1'b0;
      anomaly_vec <= '0;
      window_cnt  <= '0;
      anomaly_cnt <= '0;
      mask        <= '0;
      idx         <= '0;
      work_vec    <= '0;
      for (int i = 0; i < NUM_HPM; i++) begin
        lo[i] <= '0;
        hi[i] <= '1;
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        case (cfg_sel)
          2'd0:    lo[cfg_idx] <= cfg_wdata;
          2'd1:    hi[cfg_idx] <= cfg_wdata;
          2'd2:    mask        <= cfg_wdata[NUM_HPM-1:0];
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (EnableDetect) begin
            work_vec <= '0;
            idx      <= '0;
          end
        end
        SCAN: begin
          idx      <= idx + IDX_W'(1);
          work_vec <= vec_nx;
          if (last) begin
            anomaly_vec <= vec_nx;
            anomaly     <= |vec_nx;
            window_cnt  <= sat_inc(window_cnt);
            if (|vec_nx) anomaly_cnt <= sat_inc(anomaly_cnt);
            EndDetect   <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!EnableDetect) EndDetect <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hpm_window_detector.sv
// Directed bench for hpm_window_detector: handshake timing, bounds, saturation, config and reset.
module tb_hpm_window_detector;

  logic                 clk_h = 1'b0;
  logic                 rst_h;
  logic [31:0][63:0]    hpm;
  logic                 en;
  logic                 end_det;
  logic                 cfg_we;
  logic [1:0]           cfg_sel;
  logic [4:0]           cfg_idx;
  logic [31:0]          cfg_wdata;
  logic                 cfg_err;
  logic                 busy;
  logic                 anomaly;
  logic [31:0]          anomaly_vec;
  logic [15:0]          window_cnt;
  logic [15:0]          anomaly_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_h = ~clk_h;

  hpm_window_detector #(.NUM_HPM(32), .THR_W(32), .STAT_W(16)) dut (
    .clk_h(clk_h), .rst_h(rst_h), .HPMin(hpm), .EnableDetect(en), .EndDetect(end_det),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .busy(busy), .anomaly(anomaly), .anomaly_vec(anomaly_vec),
    .window_cnt(window_cnt), .anomaly_cnt(anomaly_cnt)
  );

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [4:0] ix, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = ix; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Request a window, wait for the ack, release, and report latency and ack after release.
  task automatic run_window(output int lat, output logic ack_after);
    en = 1'b1;
    tick();
    lat = 0;
    while (end_det !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    en = 1'b0;
    tick();
    ack_after = end_det;
  endtask

  task automatic test_reset();
    rst_h = 1'b0;
    tick();
    tick();
    n_checks++; if (end_det !== 1'b0) begin n_fail++; $display("FAIL reset_end got %b want 0", end_det); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    n_checks++; if (anomaly_vec !== 32'h0) begin n_fail++; $display("FAIL reset_vec got %h want 0", anomaly_vec); end
    n_checks++; if (window_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_wcnt got %0d want 0", window_cnt); end
    rst_h = 1'b1;
    tick();
  endtask

  task automatic test_in_range();
    int lat; logic ack;
    cfg_write(2'd2, 5'd0, 32'h4);
    cfg_write(2'd0, 5'd2, 32'd100);
    cfg_write(2'd1, 5'd2, 32'd200);
    hpm[2] = 64'd150;
    run_window(lat, ack);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL latency got %0d want 32", lat); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_release got %b want 0", ack); end
    n_checks++; if (anomaly !== 1'b0) begin n_fail++; $display("FAIL inrange_anom got %b want 0", anomaly); end
    n_checks++; if (anomaly_vec !== 32'h0) begin n_fail++; $display("FAIL inrange_vec got %h want 0", anomaly_vec); end
    n_checks++; if (window_cnt !== 16'd1) begin n_fail++; $display("FAIL inrange_wcnt got %0d want 1", window_cnt); end
  endtask

  task automatic test_back_to_back();
    int lat; logic ack;
    hpm[2] = 64'd201;
    run_window(lat, ack);
    n_checks++; if (anomaly_vec !== 32'h4) begin n_fail++; $display("FAIL above_vec got %h want 4", anomaly_vec); end
    n_checks++; if (anomaly !== 1'b1) begin n_fail++; $display("FAIL above_anom got %b want 1", anomaly); end
    hpm[2] = 64'd99;
    run_window(lat, ack);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL b2b_latency got %0d want 32", lat); end
    n_checks++; if (anomaly_vec !== 32'h4) begin n_fail++; $display("FAIL below_vec got %h want 4", anomaly_vec); end
    n_checks++; if (anomaly_cnt !== 16'd2) begin n_fail++; $display("FAIL below_acnt got %0d want 2", anomaly_cnt); end
    n_checks++; if (window_cnt !== 16'd3) begin n_fail++; $display("FAIL below_wcnt got %0d want 3", window_cnt); end
    hpm[2] = 64'd200;
    run_window(lat, ack);
    n_checks++; if (anomaly !== 1'b0) begin n_fail++; $display("FAIL edge_hi_anom got %b want 0", anomaly); end
    n_checks++; if (anomaly_cnt !== 16'd2) begin n_fail++; $display("FAIL edge_hi_acnt got %0d want 2", anomaly_cnt); end
  endtask

  task automatic test_saturation();
    int lat; logic ack;
    cfg_write(2'd2, 5'd0, 32'h1);
    cfg_write(2'd1, 5'd0, 32'hFFFF_FFFF);
    hpm[0] = 64'h1_0000_0000;
    run_window(lat, ack);
    n_checks++; if (anomaly !== 1'b0) begin n_fail++; $display("FAIL sat_pass_anom got %b want 0", anomaly); end
    cfg_write(2'd1, 5'd0, 32'hFFFF_FFFE);
    run_window(lat, ack);
    n_checks++; if (anomaly_vec !== 32'h1) begin n_fail++; $display("FAIL sat_fail_vec got %h want 1", anomaly_vec); end
    n_checks++; if (anomaly_cnt !== 16'd3) begin n_fail++; $display("FAIL sat_fail_acnt got %0d want 3", anomaly_cnt); end
    n_checks++; if (window_cnt !== 16'd6) begin n_fail++; $display("FAIL sat_wcnt got %0d want 6", window_cnt); end
  endtask

  task automatic test_hold_high();
    int lat;
    hpm[0] = 64'd0;
    en = 1'b1;
    tick();
    lat = 0;
    while (end_det !== 1'b1 && lat < 100) begin tick(); lat++; end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL hold_latency got %0d want 32", lat); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (end_det !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL hold_ack cycle %0d got end=%b busy=%b want 1/1", k, end_det, busy);
      end
    end
    en = 1'b0;
    tick();
    n_checks++; if (end_det !== 1'b0) begin n_fail++; $display("FAIL hold_release got %b want 0", end_det); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle_busy got %b want 0", busy); end
    n_checks++; if (window_cnt !== 16'd7) begin n_fail++; $display("FAIL hold_wcnt got %0d want 7", window_cnt); end
  endtask

  task automatic test_cfg_busy();
    int lat; logic ack;
    en = 1'b1;
    tick();
    tick();
    cfg_write(2'd0, 5'd5, 32'd7);
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL busy_cfg_err got %b want 1", cfg_err); end
    tick();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL busy_cfg_err_clr got %b want 0", cfg_err); end
    lat = 0;
    while (end_det !== 1'b1 && lat < 100) begin tick(); lat++; end
    en = 1'b0;
    tick();
    n_checks++; if (end_det !== 1'b0) begin n_fail++; $display("FAIL busy_release got %b want 0", end_det); end
    cfg_write(2'd2, 5'd0, 32'h20);
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL idle_cfg_err got %b want 0", cfg_err); end
    hpm[5] = 64'd3;
    run_window(lat, ack);
    n_checks++; if (anomaly !== 1'b0) begin n_fail++; $display("FAIL lo5_unchanged_anom got %b want 0", anomaly); end
    cfg_write(2'd3, 5'd0, 32'h0);
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL sel3_cfg_err got %b want 1", cfg_err); end
    tick();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL sel3_cfg_err_clr got %b want 0", cfg_err); end
  endtask

  task automatic test_reset_mid();
    int lat; logic ack;
    en = 1'b1;
    tick();
    repeat (15) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_h = 1'b0;
    en = 1'b0;
    tick();
    rst_h = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_checks++; if (end_det !== 1'b0) begin n_fail++; $display("FAIL mid_rst_end got %b want 0", end_det); end
    n_checks++; if (anomaly_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_acnt got %0d want 0", anomaly_cnt); end
    n_checks++; if (window_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_wcnt got %0d want 0", window_cnt); end
    n_checks++; if (anomaly !== 1'b0) begin n_fail++; $display("FAIL mid_rst_anom got %b want 0", anomaly); end
    run_window(lat, ack);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL post_rst_latency got %0d want 32", lat); end
    n_checks++; if (window_cnt !== 16'd1) begin n_fail++; $display("FAIL post_rst_wcnt got %0d want 1", window_cnt); end
    n_checks++; if (anomaly_vec !== 32'h0) begin n_fail++; $display("FAIL post_rst_vec got %h want 0", anomaly_vec); end
  endtask

  initial begin
    rst_h = 1'b0; en = 1'b0; hpm = '0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_idx = 5'd0; cfg_wdata = 32'h0;
    test_reset();
    test_in_range();
    test_back_to_back();
    test_saturation();
    test_hold_high();
    test_cfg_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
